mult_controller: RTL

Moore/Mealy FSM that sequences the 3-bit repeated-addition multiplier datapath (`MULT_DATAPATH`). It accepts a START/operand handshake, drives every mux, ALU and register-load control, loops on the datapath's `R2_LT_B_1` flag, and reports completion with a one-cycle DONE pulse. It sits beside `MULT_DATAPATH` in the multiplier top level; the product appears on the datapath's `F_REG`.

---
 rtl/mult_pkg.sv | 29 ++
 rtl/mult_controller_if.sv | 58 +++++
 rtl/mult_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the repeated-addition multiplier controller.
package mult_pkg;

    localparam int MULT_N = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ADD   = 3'd2,
        S_INC   = 3'd3,
        S_STORE = 3'd4,
        S_DONE  = 3'd5
    } mult_state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_INC = 2'b01;
    localparam logic [1:0] ALU_CLR = 2'b10;

    localparam logic SEL1_R1 = 1'b0;
    localparam logic SEL1_A  = 1'b1;
    localparam logic SEL2_A  = 1'b0;
    localparam logic SEL2_R2 = 1'b1;

    // ABORT is honoured only while an operation is in flight and not yet finishing
    function automatic logic abortable(input mult_state_t st);
        return (st != S_IDLE) && (st != S_DONE);
    endfunction

endpackage

// File: rtl/mult_controller_if.sv
// Control/status bundle between mult_controller and the multiplier datapath.
// ABORT exists only when MULT_CTRL_ABORT_EN is defined.
interface mult_controller_if #(parameter int N = 3) ();
    logic         START;
    logic [N-1:0] B;
    logic         R2_LT_B_1;
`ifdef MULT_CTRL_ABORT_EN
    logic         ABORT;
`endif
    logic         MUX_IN1_CONT;
    logic         MUX_IN2_CONT;
    logic [1:0]   ALU_CONT;
    logic         LOAD_A_REG;
    logic         LOAD_B_REG;
    logic         LOAD_R1_REG;
    logic         LOAD_R2_REG;
    logic         LOAD_F_REG;
    logic         BUSY;
    logic         DONE;

    modport slave (
        input  START,
        input  B,
        input  R2_LT_B_1,
`ifdef MULT_CTRL_ABORT_EN
        input  ABORT,
`endif
        output MUX_IN1_CONT,
        output MUX_IN2_CONT,
        output ALU_CONT,
        output LOAD_A_REG,
        output LOAD_B_REG,
        output LOAD_R1_REG,
        output LOAD_R2_REG,
        output LOAD_F_REG,
        output BUSY,
        output DONE
    );

    modport master (
        output START,
        output B,
        output R2_LT_B_1,
`ifdef MULT_CTRL_ABORT_EN
        output ABORT,
`endif
        input  MUX_IN1_CONT,
        input  MUX_IN2_CONT,
        input  ALU_CONT,
        input  LOAD_A_REG,
        input  LOAD_B_REG,
        input  LOAD_R1_REG,
        input  LOAD_R2_REG,
        input  LOAD_F_REG,
        input  BUSY,
        input  DONE
    );
endinterface

// File: rtl/mult_controller.sv
// Sequencer for the 3-bit repeated-addition multiplier datapath.
// Optional ABORT input enabled by defining MULT_CTRL_ABORT_EN.
module mult_controller
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic              SYS_CLOCK,
    input  logic              SYS_RESET,
    mult_controller_if.slave  bus
);

    mult_state_t state_r;
    mult_state_t next_state_s;
    logic        b_zero_r;
    logic        capture_s;
    logic        abort_s;
    logic        b_is_zero_s;

    logic        mux1_s;
    logic        mux2_s;
    logic [1:0]  alu_s;
    logic        load_a_s;
    logic        load_b_s;
    logic        load_r1_s;
    logic        load_r2_s;
    logic        load_f_s;
    logic        busy_s;
    logic        done_s;

`ifdef MULT_CTRL_ABORT_EN
    assign abort_s = bus.ABORT;
`else
    assign abort_s = 1'b0;
`endif

    // The datapath's B-1 wraps for B=0, so a zero multiplier bypasses the add loop
    assign b_is_zero_s = (bus.B == {N{1'b0}});

    // State register
    always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
        if (SYS_RESET) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Zero-multiplier flag, captured together with the operands
    always_ff @(posedge SYS_CLOCK or posedge SYS_RESET) begin
        if (SYS_RESET) begin
            b_zero_r <= 1'b0;
        end else if (capture_s) begin
            b_zero_r <= b_is_zero_s;
        end else begin
            b_zero_r <= b_zero_r;
        end
    end

    // Next-state and output decode
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        mux1_s       = SEL1_R1;
        mux2_s       = SEL2_A;
        alu_s        = ALU_CLR;
        load_a_s     = 1'b0;
        load_b_s     = 1'b0;
        load_r1_s    = 1'b0;
        load_r2_s    = 1'b0;
        load_f_s     = 1'b0;
        busy_s       = (state_r != S_IDLE);
        done_s       = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (bus.START && !abort_s) begin
                    load_a_s     = 1'b1;
                    load_b_s     = 1'b1;
                    capture_s    = 1'b1;
                    next_state_s = S_CLEAR;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                load_r1_s = 1'b1;
                load_r2_s = 1'b1;
                if (b_zero_r) begin
                    next_state_s = S_STORE;
                end else begin
                    next_state_s = S_ADD;
                end
            end
            S_ADD: begin
                mux1_s    = SEL1_R1;
                mux2_s    = SEL2_A;
                alu_s     = ALU_ADD;
                load_r1_s = 1'b1;
                if (bus.R2_LT_B_1) begin
                    next_state_s = S_INC;
                end else begin
                    next_state_s = S_STORE;
                end
            end
            S_INC: begin
                mux2_s       = SEL2_R2;
                alu_s        = ALU_INC;
                load_r2_s    = 1'b1;
                next_state_s = S_ADD;
            end
            S_STORE: begin
                load_f_s     = 1'b1;
                next_state_s = S_DONE;
            end
            S_DONE: begin
                done_s       = 1'b1;
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase

        // Abort overrides everything above: drop to IDLE without touching datapath registers
        if (abort_s && abortable(state_r)) begin
            load_r1_s    = 1'b0;
            load_r2_s    = 1'b0;
            load_f_s     = 1'b0;
            next_state_s = S_IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    assign bus.MUX_IN1_CONT = mux1_s;
    assign bus.MUX_IN2_CONT = mux2_s;
    assign bus.ALU_CONT     = alu_s;
    assign bus.LOAD_A_REG   = load_a_s;
    assign bus.LOAD_B_REG   = load_b_s;
    assign bus.LOAD_R1_REG  = load_r1_s;
    assign bus.LOAD_R2_REG  = load_r2_s;
    assign bus.LOAD_F_REG   = load_f_s;
    assign bus.BUSY         = busy_s;
    assign bus.DONE         = done_s;

endmodule
